// File: rtl/pipe_dly_arb.sv
// Round-robin arbiter feeding one requester per cycle into a shared pipe of latency LAT=DLY_NUM+1, tagging responses with the requester id.
// Grant and issue are combinational in the request cycle; there is no response backpressure, and flush kills everything in flight.
module pipe_dly_arb #(
    parameter int U_DLY   = 1,
    parameter int REQ_NUM = 4,
    parameter int DATA_W  = 32,
    parameter int DLY_NUM = 2,
    localparam int LAT    = DLY_NUM + 1,
    localparam int ID_W   = $clog2(REQ_NUM),
    localparam int CNT_W  = $clog2(LAT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_vld,
    input  logic [REQ_NUM*DATA_W-1:0] req_data,
    output logic [REQ_NUM-1:0]        req_gnt,
    input  logic                      flush,
    output logic [DATA_W-1:0]         pipe_din,
    input  logic [DATA_W-1:0]         pipe_dout,
    output logic                      rsp_vld,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]         outst_q, outst_d;
    logic [CNT_W-1:0]         drain_q, drain_d;
    logic [LAT-1:0]           trk_vld_q, trk_vld_d;
    logic [LAT-1:0][ID_W-1:0] trk_id_q, trk_id_d;

    logic [REQ_NUM-1:0]       gnt;
    logic [ID_W-1:0]          gnt_id;
    logic                     gnt_en;
    logic                     issue;
    logic                     retire;
    logic                     unused_dly;

    assign unused_dly = (U_DLY != 0);

    // Reset gates the grant so nothing can issue while rst is held low.
    assign gnt_en = rst && !flush && (state_q != DRAIN);

    always_comb begin
        logic [ID_W-1:0] idx;
        logic            found;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = ptr_q;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (gnt_en && !found && req_vld[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
            idx = (idx == ID_W'(REQ_NUM - 1)) ? '0 : idx + 1'b1;
        end
    end

    assign issue  = |gnt;
    assign retire = trk_vld_q[LAT-1];

    always_comb begin
        pipe_din = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (gnt[i]) begin
                pipe_din = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Flush empties the tracker on the same edge, so nothing issued earlier can surface.
    always_comb begin
        trk_vld_d = '0;
        trk_id_d  = '0;
        if (!flush) begin
            trk_vld_d[0] = issue;
            trk_id_d[0]  = issue ? gnt_id : '0;
            for (int s = 1; s < LAT; s++) begin
                trk_vld_d[s] = trk_vld_q[s-1];
                trk_id_d[s]  = trk_id_q[s-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        outst_d = outst_q + CNT_W'(issue) - CNT_W'(retire);
        drain_d = drain_q;
        if (flush) begin
            state_d = DRAIN;
            outst_d = '0;
            drain_d = CNT_W'(LAT);
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (outst_d == '0) begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_q <= CNT_W'(1)) begin
                        state_d = IDLE;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            outst_q   <= '0;
            drain_q   <= '0;
            trk_vld_q <= '0;
            trk_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            outst_q   <= outst_d;
            drain_q   <= drain_d;
            trk_vld_q <= trk_vld_d;
            trk_id_q  <= trk_id_d;
        end
    end

    assign req_gnt  = gnt;
    assign rsp_vld  = trk_vld_q[LAT-1];
    assign rsp_id   = rsp_vld ? trk_id_q[LAT-1] : '0;
    assign rsp_data = rsp_vld ? pipe_dout : '0;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pipe_dly_arb.sv
// Bench for pipe_dly_arb: random and directed requests against a cycle-window reference model, with a response scoreboard.
module tb_pipe_dly_arb;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DLY = 2;
    localparam int LAT = DLY + 1;
    localparam logic [DW-1:0] K = 32'h5A5A_C3C3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req_vld = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_gnt;
    logic          flush = 1'b0;
    logic [DW-1:0] pipe_din;
    logic [DW-1:0] pipe_dout;
    logic          rsp_vld;
    logic [1:0]    rsp_id;
    logic [DW-1:0] rsp_data;
    logic          busy;

    always #5 clk = ~clk;

    pipe_dly_arb #(.U_DLY(1), .REQ_NUM(N), .DATA_W(DW), .DLY_NUM(DLY)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
        .req_gnt(req_gnt), .flush(flush), .pipe_din(pipe_din), .pipe_dout(pipe_dout),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    // External shared pipe: fixed LAT-cycle delay with a data scramble.
    logic [DW-1:0] pipe_sr [LAT];
    always @(posedge clk) begin
        pipe_sr[0] <= pipe_din;
        for (int s = 1; s < LAT; s++) pipe_sr[s] <= pipe_sr[s-1];
    end
    assign pipe_dout = pipe_sr[LAT-1] ^ K;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   issues[$];
    int   last_flush = -1000;
    int   ptr_m = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Response monitor: every rsp_vld must match the oldest outstanding expectation in its due cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing t=%0d got none want id %0d", cyc, sb[0].id);
            void'(sb.pop_front());
        end
        if (rsp_vld) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("rsp_data", rsp_data, sb[0].data);
                void'(sb.pop_front());
            end else begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected t=%0d got id %0d want no response", cyc, rsp_id);
            end
        end else begin
            chk("rsp_data_idle", rsp_data, 32'h0);
        end
    end

    task automatic cycle(input logic [N-1:0] v, input logic f);
        logic [N-1:0]  eg;
        logic [N-1:0]  sh;
        logic [DW-1:0] ed;
        logic          eb;
        int            g;
        int            t;
        @(posedge clk);
        #1;
        req_vld = v;
        flush   = f;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        @(negedge clk);
        t  = cyc;
        g  = -1;
        eg = '0;
        ed = '0;
        // Grants are blocked in the flush cycle and for LAT cycles after the latest flush.
        if (!f && t > last_flush + LAT) begin
            for (int k = 0; k < N; k++) begin
                sh = v >> ((ptr_m + k) % N);
                if (g < 0 && sh[0]) g = (ptr_m + k) % N;
            end
        end
        if (g >= 0) begin
            eg = N'(1) << g;
            ed = DW'(req_data >> (g * DW));
        end
        eb = (t > last_flush) && (t <= last_flush + LAT);
        foreach (issues[j]) if (issues[j] >= t - LAT && issues[j] <= t - 1) eb = 1'b1;
        chk("req_gnt", 32'(req_gnt), 32'(eg));
        chk("pipe_din", pipe_din, ed);
        chk("busy", 32'(busy), 32'(eb));
        if (g >= 0) begin
            ptr_m = (g + 1) % N;
            issues.push_back(t);
            sb.push_back('{due: t + LAT, id: g, data: ed ^ K});
        end
        if (f) begin
            last_flush = t;
            while (sb.size() > 0 && sb[$].due > t) void'(sb.pop_back());
        end
        while (issues.size() > 0 && issues[0] < t - LAT) void'(issues.pop_front());
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        flush   = 1'b0;
        req_vld = 4'($urandom_range(1, 15));
        sb.delete();
        issues.delete();
        ptr_m      = 0;
        last_flush = -1000;
        #1;
        chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt", 32'(req_gnt), 32'h0);
        repeat (n) begin
            @(negedge clk);
            chk("rst_gnt_hold", 32'(req_gnt), 32'h0);
            chk("rst_busy_hold", 32'(busy), 32'h0);
            chk("rst_rsp_hold", 32'(rsp_vld), 32'h0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b1;
        req_vld = '0;
    endtask

    initial begin
        do_reset(2);
        // Single request from requester 2.
        cycle(4'b0100, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Full contention straight out of reset.
        do_reset(1);
        repeat (4) cycle(4'b1111, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Pointer wrap: move pointer to 3, then alternate 3/0.
        cycle(4'b0100, 1'b0);
        repeat (3) cycle(4'b1001, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Flush with two operations in flight, requests held through the drain.
        cycle(4'b0010, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b1111, 1'b1);
        repeat (3) cycle(4'b1111, 1'b0);
        cycle(4'b1000, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Flush and request in the same cycle.
        cycle(4'b0001, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Reset with an operation in flight.
        cycle(4'b0100, 1'b0);
        do_reset(2);
        cycle(4'b1010, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        // Random traffic with occasional flushes and resets.
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) do_reset($urandom_range(1, 3));
            else cycle(4'($urandom), $urandom_range(0, 23) == 0);
        end
        repeat (6) cycle(4'b0000, 1'b0);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_dly_arb.md
PIPE_DLY_ARB -- requirements
Module: pipe_dly_arb

Interface
REQ-001 Parameter U_DLY, default 1, simulation delay applied to every register update.
REQ-002 Parameter REQ_NUM, default 4, number of requesters sharing the pipe (2..16).
REQ-003 Parameter DATA_W, default 32, data width of each request and of the pipe.
REQ-004 Parameter DLY_NUM, default 2, delay setting of the shared pipe; pipe latency LAT = DLY_NUM+1 cycles.
REQ-005 Derived ID_W = clog2(REQ_NUM) and CNT_W = clog2(LAT+1).
REQ-006 The block SHALL have exactly one clock, `clk`, and one reset, `rst`, which is asynchronous and active-low.
REQ-007 Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- req_vld  in  REQ_NUM  per-requester request valid.
- req_data  in  REQ_NUM*DATA_W  per-requester data; requester i owns slice [i*DATA_W +: DATA_W].
- req_gnt  out  REQ_NUM  one-hot grant, combinational, issue occurs in grant cycle.
- flush  in  1  kill all in-flight operations.
- pipe_din  out  DATA_W  data to shared pipe input.
- pipe_dout  in  DATA_W  data from shared pipe output.
- rsp_vld  out  1  response valid.
- rsp_id  out  ID_W  requester index owning the response.
- rsp_data  out  DATA_W  response data.
- busy  out  1  in-flight work or drain in progress.

Function
REQ-008 State machine SHALL have three states: IDLE (no in-flight), ACTIVE (>=1 in-flight), DRAIN (post-flush quiet period).
REQ-009 Transitions: IDLE->ACTIVE on issue; ACTIVE->IDLE when outstanding reaches 0 with no issue; any state->DRAIN on flush; DRAIN->IDLE after LAT cycles with flush low.
REQ-010 Grant SHALL be issued only in IDLE/ACTIVE with flush low; at most one bit of req_gnt high per cycle.
REQ-011 Round-robin: search starts at pointer ptr and goes upward modulo REQ_NUM; the first requester with req_vld high is granted.
REQ-012 After a grant to i, ptr SHALL become (i+1) mod REQ_NUM; ptr holds when there is no grant.
REQ-013 pipe_din SHALL equal the granted requester's req_data in the grant cycle, else all zeros.
REQ-014 Requesters may change or drop req_vld at any time; there is no grant stickiness.
REQ-015 Valid/ID tracking: a LAT-stage shift register of {vld,id} SHALL shift every cycle; an issue at cycle T SHALL yield rsp_vld=1, rsp_id=i at cycle T+LAT, aligned with pipe_dout.
REQ-016 rsp_data SHALL be pipe_dout when rsp_vld=1, else zero.
REQ-017 Responses have no backpressure; back-to-back issues SHALL give back-to-back responses at full throughput.
REQ-018 Flush SHALL clear all tracking vld bits in the same edge, so no response emerges for any operation issued before or during the flush cycle.
REQ-019 Flush SHALL zero the outstanding count and load the drain counter with LAT.
REQ-020 Flush asserted while in DRAIN SHALL reload the drain counter; issue and flush in the same cycle resolve to flush, with no grant.
REQ-021 Outstanding counter (CNT_W bits): +1 on issue, -1 on response retire, unchanged if both occur, never exceeds LAT.
REQ-022 busy SHALL be 1 when the state is not IDLE, else 0.

Reset
REQ-023 On rst low, asynchronously: state=IDLE, ptr=0, outstanding=0, drain counter=0, all tracking vld/id=0.
REQ-024 During reset, rsp_vld=0, rsp_id=0, rsp_data=0 and busy=0; req_gnt SHALL be 0 while rst is low.
REQ-025 Reset mid-operation SHALL drop all in-flight responses; the first grant after release goes to requester 0 if requesting.

Verification (REQ_NUM=4, DLY_NUM=2, LAT=3)
REQ-026 Single request: req_vld=4'b0100, data 0xA5 at T0 -> req_gnt=4'b0100 at T0, pipe_din=0xA5; rsp_vld=1, rsp_id=2 at T3; busy=1 for T1..T3.
REQ-027 Contention: req_vld=4'b1111 held for 4 cycles from reset -> grants 0,1,2,3 in order; rsp_id 0,1,2,3 on T3..T6 consecutively.
REQ-028 Fairness wrap: ptr=3, req_vld=4'b1001 -> grant 3, then grant 0, then grant 3.
REQ-029 Flush: issues at T0,T1, flush at T2 -> no rsp_vld T2..T5; req_gnt=0 for T2..T5; grant possible again at T6; busy high T1..T5.
REQ-030 Flush + request same cycle: req_vld=4'b0001 with flush=1 -> req_gnt=0, ptr unchanged, no response.
REQ-031 Reset mid-flight: issue at T0, rst low at T1 -> rsp_vld stays 0; after release, req_vld=4'b1010 -> grant to 1.
